// File: rtl/count_pulse_gen.sv
// count_pulse_gen: burst generator emitting n_pulses count pulses of HI_LEN/LO_LEN cycles, then a one-cycle done.
// Define COUNT_PULSE_GEN_LOOP_EN to let start in DONE restart a burst without passing through IDLE.
module count_pulse_gen #(
    parameter int N_W    = 4,
    parameter int HI_LEN = 5,
    parameter int LO_LEN = 5,
    parameter int LEN_W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] n_pulses,
    output logic           count,
    output logic           busy,
    output logic           done,
    output logic [1:0]     s_out,
    output logic [N_W-1:0] sent
);
    typedef enum logic [1:0] {IDLE = 2'b00, HIGH = 2'b01, LOW = 2'b10, DONE = 2'b11} state_t;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [N_W-1:0]   n_q, n_d, sent_q, sent_d;
    logic             count_q, count_d;
    logic             accept;
`ifdef COUNT_PULSE_GEN_LOOP_EN
    assign accept = start && (state_q == IDLE || state_q == DONE);
`else
    assign accept = start && state_q == IDLE;
`endif
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        n_d     = n_q;
        sent_d  = sent_q;
        if (accept) begin
            n_d     = n_pulses;
            sent_d  = '0;
            len_d   = '0;
            state_d = n_pulses != '0 ? HIGH : DONE;
        end else begin
            case (state_q)
                HIGH: begin
                    len_d   = len_q == LEN_W'(HI_LEN - 1) ? '0 : len_q + 1'b1;
                    state_d = len_q == LEN_W'(HI_LEN - 1) ? LOW : HIGH;
                    sent_d  = len_q == LEN_W'(HI_LEN - 1) ? sent_q + 1'b1 : sent_q;
                end
                LOW: begin
                    len_d   = len_q == LEN_W'(LO_LEN - 1) ? '0 : len_q + 1'b1;
                    state_d = len_q != LEN_W'(LO_LEN - 1) ? LOW : (sent_q == n_q ? DONE : HIGH);
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        count_d = state_d == HIGH;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            n_q     <= '0;
            sent_q  <= '0;
            count_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            n_q     <= n_d;
            sent_q  <= sent_d;
            count_q <= count_d;
        end
    end
    assign count = count_q;
    assign busy  = state_q != IDLE;
    assign done  = state_q == DONE;
    assign s_out = state_q;
    assign sent  = sent_q;
endmodule
